// File: rtl/stack_controller_if.sv
// rtl/stack_controller_if.sv - Controller <-> datapath bundle: opcode/zero in, control strobes and selects out
interface stack_controller_if;
  // Datapath status seen by the controller
  logic [2:0] opcode;
  logic       zero;
  // Control strobes and selects driven by the controller
  logic       IorD;
  logic       PC_write;
  logic       PC_src;
  logic       mem_read;
  logic       mem_write;
  logic       IR_write;
  logic       push;
  logic       pop;
  logic       tos;
  logic       A_write;
  logic       B_write;
  logic       ALU_srcA;
  logic [1:0] ALU_srcB;
  logic [1:0] push_src;
  logic [1:0] ALU_control;
  logic       AorB;

  modport master (
    input  opcode, zero,
    output IorD, PC_write, PC_src, mem_read, mem_write, IR_write,
           push, pop, tos, A_write, B_write,
           ALU_srcA, ALU_srcB, push_src, ALU_control, AorB
  );

  modport slave (
    output opcode, zero,
    input  IorD, PC_write, PC_src, mem_read, mem_write, IR_write,
           push, pop, tos, A_write, B_write,
           ALU_srcA, ALU_srcB, push_src, ALU_control, AorB
  );
endinterface

// File: rtl/stack_controller.sv
// rtl/stack_controller.sv - Multi-cycle Moore control FSM for the stack processor (debug ports under CTRL_DBG_EN)
module stack_controller (
  input  logic clk,
  input  logic rst,
`ifdef CTRL_DBG_EN
  output logic [3:0] dbg_state,
  output logic       instr_done,
`endif
  stack_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_POP_A    = 4'd2,
    S_POP_B    = 4'd3,
    S_EXEC     = 4'd4,
    S_PUSH_RES = 4'd5,
    S_MEM_RD   = 4'd6,
    S_PUSH_MEM = 4'd7,
    S_MEM_WR   = 4'd8,
    S_JMP      = 4'd9,
    S_TOS_A    = 4'd10,
    S_TEST     = 4'd11
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  typedef struct packed {
    logic       IorD;
    logic       PC_write;
    logic       PC_src;
    logic       mem_read;
    logic       mem_write;
    logic       IR_write;
    logic       push;
    logic       pop;
    logic       tos;
    logic       A_write;
    logic       B_write;
    logic       ALU_srcA;
    logic [1:0] ALU_srcB;
    logic [1:0] push_src;
    logic [1:0] ALU_control;
  } ctrl_t;

  // Control word for a state; evaluated on the next state so the outputs come straight from flops.
  // TEST's PC_write depends on the live zero flag and is added at the output stage instead.
  function automatic ctrl_t decode(input state_t s, input logic [1:0] alu_op);
    ctrl_t c;
    c = '0;
    case (s)
      S_IF: begin
        c.mem_read = 1'b1;
        c.IR_write = 1'b1;
        c.ALU_srcB = 2'b01;
        c.PC_write = 1'b1;
      end
      S_POP_A: begin
        c.pop     = 1'b1;
        c.A_write = 1'b1;
      end
      S_POP_B: begin
        c.pop     = 1'b1;
        c.B_write = 1'b1;
      end
      S_EXEC: begin
        c.ALU_srcA    = 1'b1;
        c.ALU_srcB    = 2'b00;
        c.ALU_control = alu_op;
      end
      S_PUSH_RES: begin
        c.push_src = 2'b10;
        c.push     = 1'b1;
      end
      S_MEM_RD: begin
        c.IorD     = 1'b1;
        c.mem_read = 1'b1;
      end
      S_PUSH_MEM: begin
        c.push_src = 2'b00;
        c.push     = 1'b1;
      end
      S_MEM_WR: begin
        c.IorD      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_JMP: begin
        c.PC_src   = 1'b1;
        c.PC_write = 1'b1;
      end
      S_TOS_A: begin
        c.tos     = 1'b1;
        c.A_write = 1'b1;
      end
      S_TEST: begin
        c.ALU_srcA    = 1'b1;
        c.ALU_srcB    = 2'b10;
        c.ALU_control = 2'b00;
        c.PC_src      = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t     state_q, state_d;
  logic [1:0] alu_op_q, alu_op_d;
  ctrl_t      ctrl_q;
  logic       out_en;

  // Next-state selection; the opcode is looked at only in ID and POP_A, and the ALU op is latched in ID
  always_comb begin
    state_d  = S_IF;
    alu_op_d = alu_op_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        alu_op_d = bus.opcode[1:0];
        case (bus.opcode)
          OP_ADD, OP_SUB, OP_AND, OP_NOT, OP_POP: state_d = S_POP_A;
          OP_PUSH: state_d = S_MEM_RD;
          OP_JMP:  state_d = S_JMP;
          OP_JZ:   state_d = S_TOS_A;
          default: state_d = S_IF;
        endcase
      end
      S_POP_A: begin
        case (bus.opcode)
          OP_ADD, OP_SUB, OP_AND: state_d = S_POP_B;
          OP_NOT:  state_d = S_EXEC;
          OP_POP:  state_d = S_MEM_WR;
          default: state_d = S_IF;
        endcase
      end
      S_POP_B:    state_d = S_EXEC;
      S_EXEC:     state_d = S_PUSH_RES;
      S_PUSH_RES: state_d = S_IF;
      S_MEM_RD:   state_d = S_PUSH_MEM;
      S_PUSH_MEM: state_d = S_IF;
      S_MEM_WR:   state_d = S_IF;
      S_JMP:      state_d = S_IF;
      S_TOS_A:    state_d = S_TEST;
      S_TEST:     state_d = S_IF;
      default:    state_d = S_IF;
    endcase
  end

  // State, latched ALU op and registered control word
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IF;
      alu_op_q <= 2'b00;
      ctrl_q   <= decode(S_IF, 2'b00);
    end else begin
      state_q  <= state_d;
      alu_op_q <= alu_op_d;
      ctrl_q   <= decode(state_d, alu_op_d);
    end
  end

  // Reset and any out-of-range state silence every output at once, without waiting for an edge
  assign out_en = ~rst && (state_q <= S_TEST);

  assign bus.IorD        = out_en & ctrl_q.IorD;
  assign bus.PC_write    = out_en & (ctrl_q.PC_write | ((state_q == S_TEST) & bus.zero));
  assign bus.PC_src      = out_en & ctrl_q.PC_src;
  assign bus.mem_read    = out_en & ctrl_q.mem_read;
  assign bus.mem_write   = out_en & ctrl_q.mem_write;
  assign bus.IR_write    = out_en & ctrl_q.IR_write;
  assign bus.push        = out_en & ctrl_q.push;
  assign bus.pop         = out_en & ctrl_q.pop;
  assign bus.tos         = out_en & ctrl_q.tos;
  assign bus.A_write     = out_en & ctrl_q.A_write;
  assign bus.B_write     = out_en & ctrl_q.B_write;
  assign bus.ALU_srcA    = out_en & ctrl_q.ALU_srcA;
  assign bus.ALU_srcB    = out_en ? ctrl_q.ALU_srcB : 2'b00;
  assign bus.push_src    = out_en ? ctrl_q.push_src : 2'b00;
  assign bus.ALU_control = out_en ? ctrl_q.ALU_control : 2'b00;
  assign bus.AorB        = 1'b0;

`ifdef CTRL_DBG_EN
  // Debug view: current state and a pulse in each instruction's final cycle
  assign dbg_state  = out_en ? state_q : 4'd0;
  assign instr_done = out_en & (state_q inside {S_PUSH_RES, S_PUSH_MEM, S_MEM_WR, S_JMP, S_TEST});
`endif

endmodule

// File: tb/tb_stack_controller.sv
// tb/tb_stack_controller.sv - Directed self-checking bench for stack_controller (debug checks under CTRL_DBG_EN)
module tb_stack_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stack_controller_if bus ();

`ifdef CTRL_DBG_EN
  logic [3:0] dbg_state;
  logic       instr_done;
`endif

  stack_controller dut (
    .clk        (clk),
    .rst        (rst),
`ifdef CTRL_DBG_EN
    .dbg_state  (dbg_state),
    .instr_done (instr_done),
`endif
    .bus        (bus)
  );

  // {IorD, PC_write, PC_src, mem_read, mem_write, IR_write, push, pop, tos,
  //  A_write, B_write, ALU_srcA, ALU_srcB[1:0], push_src[1:0], ALU_control[1:0], AorB}
  logic [18:0] obs;
  assign obs = {bus.IorD, bus.PC_write, bus.PC_src, bus.mem_read, bus.mem_write, bus.IR_write,
                bus.push, bus.pop, bus.tos, bus.A_write, bus.B_write, bus.ALU_srcA,
                bus.ALU_srcB, bus.push_src, bus.ALU_control, bus.AorB};

  localparam logic [18:0] E_ZERO     = 19'b0;
  localparam logic [18:0] E_IF       = 19'b0_1_0_1_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [18:0] E_ID       = 19'b0_0_0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [18:0] E_POP_A    = 19'b0_0_0_0_0_0_0_1_0_1_0_0_00_00_00_0;
  localparam logic [18:0] E_POP_B    = 19'b0_0_0_0_0_0_0_1_0_0_1_0_00_00_00_0;
  localparam logic [18:0] E_EXEC_ADD = 19'b0_0_0_0_0_0_0_0_0_0_0_1_00_00_00_0;
  localparam logic [18:0] E_EXEC_SUB = 19'b0_0_0_0_0_0_0_0_0_0_0_1_00_00_01_0;
  localparam logic [18:0] E_EXEC_AND = 19'b0_0_0_0_0_0_0_0_0_0_0_1_00_00_10_0;
  localparam logic [18:0] E_EXEC_NOT = 19'b0_0_0_0_0_0_0_0_0_0_0_1_00_00_11_0;
  localparam logic [18:0] E_PUSH_RES = 19'b0_0_0_0_0_0_1_0_0_0_0_0_00_10_00_0;
  localparam logic [18:0] E_MEM_RD   = 19'b1_0_0_1_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [18:0] E_PUSH_MEM = 19'b0_0_0_0_0_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [18:0] E_MEM_WR   = 19'b1_0_0_0_1_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [18:0] E_JMP      = 19'b0_1_1_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [18:0] E_TOS_A    = 19'b0_0_0_0_0_0_0_0_1_1_0_0_00_00_00_0;
  localparam logic [18:0] E_TEST_Z0  = 19'b0_0_1_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [18:0] E_TEST_Z1  = 19'b0_1_1_0_0_0_0_0_0_0_0_1_10_00_00_0;

  int total = 0;
  int bad   = 0;

  // Hold reset two cycles, release into IF, then reset again to leave a clean IF start
  task automatic test_reset();
    rst        = 1'b1;
    bus.opcode = 3'b000;
    bus.zero   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (obs !== E_ZERO) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got %b expected %b", i, obs, E_ZERO);
      end
`ifdef CTRL_DBG_EN
      total++;
      if (dbg_state !== 4'd0 || instr_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_dbg[%0d]: got state=%0d done=%b expected 0/0", i, dbg_state, instr_done);
      end
`endif
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== E_IF) begin
      bad++;
      $display("FAIL reset_first_if: got %b expected %b", obs, E_IF);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    total++;
    if (obs !== E_ZERO) begin
      bad++;
      $display("FAIL reset_reassert: got %b expected %b", obs, E_ZERO);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ADD/SUB/AND take 6 cycles, NOT takes 5; EXEC carries the opcode's ALU function
  task automatic test_alu_ops();
    logic [18:0] ev [6];
    logic [3:0]  es [6];
    int n;
    for (int op = 0; op < 4; op++) begin
      bus.opcode = 3'(op);
      ev[0] = E_IF;  es[0] = 4'd0;
      ev[1] = E_ID;  es[1] = 4'd1;
      ev[2] = E_POP_A; es[2] = 4'd2;
      if (op == 3) begin
        n = 5;
        ev[3] = E_EXEC_NOT; es[3] = 4'd4;
        ev[4] = E_PUSH_RES; es[4] = 4'd5;
      end else begin
        n = 6;
        ev[3] = E_POP_B; es[3] = 4'd3;
        ev[4] = (op == 0) ? E_EXEC_ADD : (op == 1) ? E_EXEC_SUB : E_EXEC_AND;
        es[4] = 4'd4;
        ev[5] = E_PUSH_RES; es[5] = 4'd5;
      end
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        total++;
        if (obs !== ev[i]) begin
          bad++;
          $display("FAIL alu_op%0d_cycle%0d: got %b expected %b", op, i, obs, ev[i]);
        end
`ifdef CTRL_DBG_EN
        total++;
        if (dbg_state !== es[i] || instr_done !== (i == n - 1)) begin
          bad++;
          $display("FAIL alu_op%0d_dbg%0d: got state=%0d done=%b expected %0d/%b",
                   op, i, dbg_state, instr_done, es[i], (i == n - 1));
        end
`endif
      end
    end
  endtask

  // PUSH a: IF, ID, MEM_RD, PUSH_MEM
  task automatic test_push();
    logic [18:0] ev [4];
    ev[0] = E_IF; ev[1] = E_ID; ev[2] = E_MEM_RD; ev[3] = E_PUSH_MEM;
    bus.opcode = 3'b100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (obs !== ev[i]) begin
        bad++;
        $display("FAIL push_cycle%0d: got %b expected %b", i, obs, ev[i]);
      end
    end
  endtask

  // POP a: IF, ID, POP_A, MEM_WR (write with no read)
  task automatic test_pop();
    logic [18:0] ev [4];
    ev[0] = E_IF; ev[1] = E_ID; ev[2] = E_POP_A; ev[3] = E_MEM_WR;
    bus.opcode = 3'b101;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (obs !== ev[i]) begin
        bad++;
        $display("FAIL pop_cycle%0d: got %b expected %b", i, obs, ev[i]);
      end
    end
  endtask

  // JMP a: IF, ID, JMP
  task automatic test_jmp();
    logic [18:0] ev [3];
    ev[0] = E_IF; ev[1] = E_ID; ev[2] = E_JMP;
    bus.opcode = 3'b110;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (obs !== ev[i]) begin
        bad++;
        $display("FAIL jmp_cycle%0d: got %b expected %b", i, obs, ev[i]);
      end
    end
  endtask

  // JZ a with zero high then low: PC_write in TEST follows zero, and nothing pops
  task automatic test_jz();
    logic [18:0] ev [4];
    bus.opcode = 3'b111;
    for (int z = 1; z >= 0; z--) begin
      bus.zero = 1'(z);
      ev[0] = E_IF; ev[1] = E_ID; ev[2] = E_TOS_A;
      ev[3] = (z == 1) ? E_TEST_Z1 : E_TEST_Z0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        total++;
        if (obs !== ev[i]) begin
          bad++;
          $display("FAIL jz_z%0d_cycle%0d: got %b expected %b", z, i, obs, ev[i]);
        end
      end
    end
    bus.zero = 1'b0;
  endtask

  // Back-to-back mix: PUSH, NOT, JMP with no idle cycles in between
  task automatic test_back_to_back();
    logic [18:0] ev [12];
    logic [2:0]  eo [12];
    ev[0] = E_IF; ev[1] = E_ID; ev[2] = E_MEM_RD;   ev[3] = E_PUSH_MEM;
    ev[4] = E_IF; ev[5] = E_ID; ev[6] = E_POP_A;    ev[7] = E_EXEC_NOT; ev[8] = E_PUSH_RES;
    ev[9] = E_IF; ev[10] = E_ID; ev[11] = E_JMP;
    for (int i = 0; i < 4; i++)  eo[i] = 3'b100;
    for (int i = 4; i < 9; i++)  eo[i] = 3'b011;
    for (int i = 9; i < 12; i++) eo[i] = 3'b110;
    for (int i = 0; i < 12; i++) begin
      bus.opcode = eo[i];
      @(negedge clk);
      total++;
      if (obs !== ev[i]) begin
        bad++;
        $display("FAIL b2b_cycle%0d: got %b expected %b", i, obs, ev[i]);
      end
    end
  endtask

  // Reset during POP_B of SUB: silent at once, no push afterwards, then a full SUB from IF
  task automatic test_reset_mid();
    logic [18:0] ev [6];
    logic [3:0]  es [6];
    bus.opcode = 3'b001;
    ev[0] = E_IF; ev[1] = E_ID; ev[2] = E_POP_A;
    es[0] = 4'd0; es[1] = 4'd1; es[2] = 4'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (obs !== ev[i]) begin
        bad++;
        $display("FAIL rstmid_pre%0d: got %b expected %b", i, obs, ev[i]);
      end
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    total++;
    if (obs !== E_ZERO) begin
      bad++;
      $display("FAIL rstmid_in_pop_b: got %b expected %b", obs, E_ZERO);
    end
`ifdef CTRL_DBG_EN
    total++;
    if (dbg_state !== 4'd0 || instr_done !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_dbg: got state=%0d done=%b expected 0/0", dbg_state, instr_done);
    end
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    ev[0] = E_IF; ev[1] = E_ID; ev[2] = E_POP_A; ev[3] = E_POP_B; ev[4] = E_EXEC_SUB; ev[5] = E_PUSH_RES;
    es[0] = 4'd0; es[1] = 4'd1; es[2] = 4'd2; es[3] = 4'd3; es[4] = 4'd4; es[5] = 4'd5;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (obs !== ev[i]) begin
        bad++;
        $display("FAIL rstmid_post%0d: got %b expected %b", i, obs, ev[i]);
      end
`ifdef CTRL_DBG_EN
      total++;
      if (dbg_state !== es[i] || instr_done !== (i == 5)) begin
        bad++;
        $display("FAIL rstmid_post_dbg%0d: got state=%0d done=%b expected %0d/%b",
                 i, dbg_state, instr_done, es[i], (i == 5));
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_push();
    test_pop();
    test_jmp();
    test_jz();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
